// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing bus of the scoreboarded register file: two read
// ports with busy flags, one write port, one issue port, ready and err.
interface reg_file_sb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              ready;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;
  logic              rd1_busy;
  logic              rd2_busy;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  wd;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              err;

  modport master (
    input  ready, rd1, rd2, rd1_busy, rd2_busy, err,
    output ra1, ra2, we, wa, wd, iss_valid, iss_addr
  );

  modport slave (
    output ready, rd1, rd2, rd1_busy, rd2_busy, err,
    input  ra1, ra2, we, wa, wd, iss_valid, iss_addr
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with RAW-hazard scoreboard and post-reset clearing sequencer.
// Optional write-through read forwarding is enabled by REG_FILE_SB_BYPASS_EN.
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              run;
  logic              wr_ok;
  logic              iss_ok;
  logic [WIDTH-1:0]  rd1_d, rd2_d;
  logic              rd1_busy_d, rd2_busy_d;

  // Address is inside the array and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign run    = (state_q == RUN);
  assign wr_ok  = run && bus.we && addr_ok(bus.wa);
  assign iss_ok = run && bus.iss_valid && addr_ok(bus.iss_addr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Issue is applied after the write so a same-cycle issue leaves the entry
  // pending; the write retires the old pending entry, so that is not a WAW.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (wr_ok) busy_d[bus.wa] = 1'b0;
    if (iss_ok) begin
      busy_d[bus.iss_addr] = 1'b1;
      if (busy_q[bus.iss_addr] && !(wr_ok && (bus.wa == bus.iss_addr)))
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Array is never touched by rst itself; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT)
        mem_q[cnt_q] <= '0;
      else if (wr_ok)
        mem_q[bus.wa] <= bus.wd;
    end
  end

  always_comb begin
    rd1_d      = '0;
    rd1_busy_d = 1'b0;
    if (addr_ok(bus.ra1)) begin
      rd1_d      = mem_q[bus.ra1];
      rd1_busy_d = run && busy_q[bus.ra1];
    end
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_ok && (bus.wa == bus.ra1)) begin
      rd1_d      = bus.wd;
      rd1_busy_d = iss_ok && (bus.iss_addr == bus.ra1);
    end
`endif
  end

  always_comb begin
    rd2_d      = '0;
    rd2_busy_d = 1'b0;
    if (addr_ok(bus.ra2)) begin
      rd2_d      = mem_q[bus.ra2];
      rd2_busy_d = run && busy_q[bus.ra2];
    end
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_ok && (bus.wa == bus.ra2)) begin
      rd2_d      = bus.wd;
      rd2_busy_d = iss_ok && (bus.iss_addr == bus.ra2);
    end
`endif
  end

  assign bus.rd1      = rd1_d;
  assign bus.rd2      = rd2_d;
  assign bus.rd1_busy = rd1_busy_d;
  assign bus.rd2_busy = rd2_busy_d;
  assign bus.ready    = run;
  assign bus.err      = err_q;

endmodule
